// File: rtl/acao_scheduler.sv
// Speed-scaled action sequencer: turns a base tick into action-advance strobes at a rate
// chosen by a button-cycled speed mode (STOP/SLOW/MED/FAST), all on a single clock.
module acao_scheduler #(
    parameter int unsigned ACT_MAX  = 7,
    parameter int unsigned DIV_SLOW = 4,
    parameter int unsigned DIV_MED  = 2,
    parameter int unsigned DIV_FAST = 1,
    parameter int unsigned PRE_W    = 3
) (
    input  logic       clk,
    input  logic       rst_but,
    input  logic       tick,
    input  logic       btn_spd,
    input  logic       act_clr,
    input  logic       on_off,
    output logic [1:0] spd,
    output logic [2:0] act,
    output logic       act_strobe
);

    typedef enum logic [1:0] {
        StStop = 2'b00,
        StSlow = 2'b01,
        StMed  = 2'b10,
        StFast = 2'b11
    } spd_e;

    spd_e             spd_q;
    spd_e             spd_nxt;
    logic [2:0]       act_q;
    logic             strobe_q;
    logic             btn_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_last;
    logic             press;

    always_comb begin
        press    = btn_spd & ~btn_q;
        pre_last = '0;
        spd_nxt  = StStop;
        unique case (spd_q)
            StStop: begin
                pre_last = '0;
                spd_nxt  = StSlow;
            end
            StSlow: begin
                pre_last = PRE_W'(DIV_SLOW - 1);
                spd_nxt  = StMed;
            end
            StMed: begin
                pre_last = PRE_W'(DIV_MED - 1);
                spd_nxt  = StFast;
            end
            StFast: begin
                pre_last = PRE_W'(DIV_FAST - 1);
                spd_nxt  = StStop;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_but) begin
            spd_q    <= StStop;
            act_q    <= '0;
            strobe_q <= 1'b0;
            pre_q    <= '0;
            btn_q    <= 1'b0;
        end else begin
            // Edge register tracks the button even while frozen, so no phantom press on resume.
            btn_q    <= btn_spd;
            strobe_q <= 1'b0;
            if (on_off) begin
                if (press) begin
                    spd_q <= spd_nxt;
                    pre_q <= '0;
                end
                if (act_clr) begin
                    act_q <= '0;
                    pre_q <= '0;
                end else if (!press && spd_q != StStop && tick) begin
                    if (pre_q == pre_last) begin
                        act_q    <= (act_q == 3'(ACT_MAX)) ? 3'd0 : act_q + 3'd1;
                        pre_q    <= '0;
                        strobe_q <= 1'b1;
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
            end
        end
    end

    assign spd        = spd_q;
    assign act        = act_q;
    assign act_strobe = strobe_q;

endmodule

// File: tb/tb_acao_scheduler.sv
// Self-checking bench for acao_scheduler: scripted scenarios plus randomized traffic checked
// against a tick-counting reference model.
module tb_acao_scheduler;

    localparam int ACT_MAX = 7;

    logic       clk;
    logic       rst_but;
    logic       tick;
    logic       btn_spd;
    logic       act_clr;
    logic       on_off;
    logic [1:0] spd;
    logic [2:0] act;
    logic       act_strobe;

    int checks = 0;
    int passed = 0;

    // Reference model: mode number, action number, ticks counted since last step or mode entry.
    int m_spd = 0;
    int m_act = 0;
    int m_cnt = 0;
    bit m_strobe = 0;
    bit m_btn_prev = 0;
    int div_tab[4] = '{0, 4, 2, 1};

    acao_scheduler dut (
        .clk        (clk),
        .rst_but    (rst_but),
        .tick       (tick),
        .btn_spd    (btn_spd),
        .act_clr    (act_clr),
        .on_off     (on_off),
        .spd        (spd),
        .act        (act),
        .act_strobe (act_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        bit press;
        if (!rst_but) begin
            m_spd = 0; m_act = 0; m_cnt = 0; m_strobe = 0; m_btn_prev = 0;
        end else begin
            press = btn_spd && !m_btn_prev;
            m_btn_prev = btn_spd;
            m_strobe = 0;
            if (on_off) begin
                if (press) begin
                    m_spd = (m_spd + 1) % 4;
                    m_cnt = 0;
                end
                if (act_clr) begin
                    m_act = 0;
                    m_cnt = 0;
                end else if (!press && tick && m_spd != 0) begin
                    m_cnt++;
                    if (m_cnt == div_tab[m_spd]) begin
                        m_act = (m_act == ACT_MAX) ? 0 : m_act + 1;
                        m_cnt = 0;
                        m_strobe = 1;
                    end
                end
            end
        end
    endtask

    // Apply inputs for one clock, advance the model, then settle past the edge.
    task automatic drive(input bit r, input bit t, input bit b, input bit c, input bit o);
        rst_but = r; tick = t; btn_spd = b; act_clr = c; on_off = o;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic press_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 1, 0, 1);
            drive(1, 0, 0, 0, 1);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, (i % 2 == 0), (i % 2 == 1), 0, 1);
            checks++;
            if (spd !== 2'b00 || act !== 3'd0 || act_strobe !== 1'b0)
                $display("FAIL reset_hold cyc%0d: spd=%b act=%0d strobe=%b, want 00/0/0",
                         i, spd, act, act_strobe);
            else passed++;
        end
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 1);
        checks++;
        if (spd !== 2'b00 || act !== 3'd0)
            $display("FAIL reset_release: spd=%b act=%0d, want 00/0", spd, act);
        else passed++;
    endtask

    task automatic test_mode_cycling();
        logic [1:0] exp_seq[5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0, 1);
            checks++;
            if (spd !== exp_seq[i])
                $display("FAIL mode_step%0d: spd=%b, want %b", i, spd, exp_seq[i]);
            else passed++;
            drive(1, 0, 0, 0, 1);
        end
        for (int i = 0; i < 20; i++) drive(1, 0, 1, 0, 1);
        checks++;
        if (spd !== 2'b10)
            $display("FAIL mode_held_button: spd=%b, want 10", spd);
        else passed++;
        drive(1, 0, 0, 0, 1);
    endtask

    task automatic test_slow_rate();
        int strobes = 0;
        do_reset();
        press_n(1);
        for (int k = 1; k <= 16; k++) begin
            drive(1, 1, 0, 0, 1);
            if (act_strobe === 1'b1) strobes++;
            checks++;
            if (act_strobe !== (k % 4 == 0))
                $display("FAIL slow_tick%0d: strobe=%b, want %b", k, act_strobe, (k % 4 == 0));
            else passed++;
            drive(1, 0, 0, 0, 1);
            drive(1, 0, 0, 0, 1);
        end
        checks++;
        if (act !== 3'd4 || strobes != 4)
            $display("FAIL slow_final: act=%0d strobes=%0d, want 4/4", act, strobes);
        else passed++;
    endtask

    task automatic test_wrap_fast();
        logic [2:0] exp_seq[3] = '{3'd7, 3'd0, 3'd1};
        do_reset();
        press_n(3);
        for (int i = 0; i < 6; i++) drive(1, 1, 0, 0, 1);
        checks++;
        if (act !== 3'd6) $display("FAIL fast_preload: act=%0d, want 6", act);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 1);
            checks++;
            if (act !== exp_seq[i] || act_strobe !== 1'b1)
                $display("FAIL fast_wrap%0d: act=%0d strobe=%b, want %0d/1",
                         i, act, act_strobe, exp_seq[i]);
            else passed++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_n(2);
        drive(1, 1, 0, 0, 1);
        drive(1, 1, 1, 0, 1);
        checks++;
        if (spd !== 2'b11 || act !== 3'd0 || act_strobe !== 1'b0)
            $display("FAIL press_tick: spd=%b act=%0d strobe=%b, want 11/0/0",
                     spd, act, act_strobe);
        else passed++;
        drive(1, 1, 0, 0, 1);
        checks++;
        if (act !== 3'd1 || act_strobe !== 1'b1)
            $display("FAIL after_press_tick: act=%0d strobe=%b, want 1/1", act, act_strobe);
        else passed++;
        drive(1, 1, 0, 1, 1);
        checks++;
        if (act !== 3'd0 || act_strobe !== 1'b0)
            $display("FAIL clr_tick: act=%0d strobe=%b, want 0/0", act, act_strobe);
        else passed++;
    endtask

    task automatic test_freeze();
        do_reset();
        press_n(2);
        for (int i = 0; i < 7; i++) drive(1, 1, 0, 0, 1);
        checks++;
        if (act !== 3'd3 || spd !== 2'b10)
            $display("FAIL freeze_setup: act=%0d spd=%b, want 3/10", act, spd);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, (i == 5), (i == 7), 0);
            checks++;
            if (act !== 3'd3 || spd !== 2'b10 || act_strobe !== 1'b0)
                $display("FAIL freeze_hold%0d: act=%0d spd=%b strobe=%b, want 3/10/0",
                         i, act, spd, act_strobe);
            else passed++;
        end
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 1);
        checks++;
        if (spd !== 2'b10)
            $display("FAIL freeze_no_phantom: spd=%b, want 10", spd);
        else passed++;
        drive(1, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 1);
        checks++;
        if (act !== 3'd4 || act_strobe !== 1'b1)
            $display("FAIL freeze_resume: act=%0d strobe=%b, want 4/1", act, act_strobe);
        else passed++;
    endtask

    task automatic test_random();
        bit b = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 1) == 1), b,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0));
            checks++;
            if (spd !== 2'(m_spd) || act !== 3'(m_act) || act_strobe !== m_strobe)
                $display("FAIL random_cyc%0d: spd=%b act=%0d strobe=%b, want %0d/%0d/%b",
                         i, spd, act, act_strobe, m_spd, m_act, m_strobe);
            else passed++;
        end
    endtask

    initial begin
        rst_but = 0; tick = 0; btn_spd = 0; act_clr = 0; on_off = 1;
        test_reset();
        test_mode_cycling();
        test_slow_rate();
        test_wrap_fast();
        test_simultaneous();
        test_freeze();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
